// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and helpers for the pipelined segmented adder.
package adder_pkg;

    localparam int A_WIDTH_DEFAULT = 62;
    localparam int B_WIDTH_DEFAULT = 17;
    localparam int STAGES_DEFAULT  = 4;

    // Integer ceiling division, used to size the carry segments.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// adder_segment: one ripple-carry slice of the pipelined adder.
module adder_segment #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    // Bit-by-bit ripple from the segment LSB to its MSB.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/pipelined_custom_adder.sv
// pipelined_custom_adder: A + ext(B) split LSB-first into STAGES ripple
// segments, one segment per pipeline stage.
// Optional macro SIGN_EXT_B_EN: treat A/B as two's complement, sign-extend B
// and produce the sign in Sum[A_WIDTH]; otherwise B is zero-extended and the
// MSB is the carry-out.
//
// Handshake: an operand pair transfers when in_valid && in_ready, a result
// transfers when out_valid && out_ready. The whole pipe moves together on
// advance = !out_valid || out_ready; in_ready is advance, so nothing is
// accepted while the output is blocked. Empty slots travel as valid=0.
module pipelined_custom_adder
    import adder_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEFAULT,
    parameter int B_WIDTH = B_WIDTH_DEFAULT,
    parameter int STAGES  = STAGES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH:0]   Sum
);

    localparam int SEG = ceil_div(A_WIDTH, STAGES);

    logic               advance;
    logic [A_WIDTH-1:0] b_ext;

`ifdef SIGN_EXT_B_EN
    assign b_ext = A_WIDTH'($signed(B));
`else
    assign b_ext = A_WIDTH'(B);
`endif

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Bit range of this segment; later segments take whatever is left.
        localparam int LO      = (k * SEG > A_WIDTH) ? A_WIDTH : k * SEG;
        localparam int NEXT_LO = ((k + 1) * SEG > A_WIDTH) ? A_WIDTH : (k + 1) * SEG;
        localparam int W       = NEXT_LO - LO;
        localparam int IN_W    = A_WIDTH - LO;
        localparam int REM     = A_WIDTH - NEXT_LO;
        localparam int REM_W   = (REM > 0) ? REM : 1;

        // Stage registers: completed low sum bits, carry (or final sign),
        // slot valid, and the operand bits still waiting to be added.
        logic [NEXT_LO-1:0] s_r;
        logic               c_r;
        logic               v_r;
        logic [REM_W-1:0]   a_r;
        logic [REM_W-1:0]   b_r;

        logic [NEXT_LO-1:0] s_next;
        logic               c_store;
        logic               c_in;
        logic               v_in;

        if (k == 0) begin : g_head
            assign c_in = 1'b0;
            assign v_in = in_valid;
        end else begin : g_link
            assign c_in = g_stage[k-1].c_r;
            assign v_in = g_stage[k-1].v_r;
        end

        if (W > 0) begin : g_add
            logic [IN_W-1:0] op_a;
            logic [IN_W-1:0] op_b;
            logic [W-1:0]    seg_sum;
            logic            seg_cout;

            if (k == 0) begin : g_src_in
                assign op_a = A;
                assign op_b = b_ext;
            end else begin : g_src_pipe
                assign op_a = g_stage[k-1].a_r;
                assign op_b = g_stage[k-1].b_r;
            end

            adder_segment #(.WIDTH(W)) u_seg (
                .a    (op_a[W-1:0]),
                .b    (op_b[W-1:0]),
                .cin  (c_in),
                .sum  (seg_sum),
                .cout (seg_cout)
            );

            if (k == 0) begin : g_sum_first
                assign s_next = seg_sum;
            end else begin : g_sum_append
                assign s_next = {seg_sum, g_stage[k-1].s_r};
            end

            if (REM == 0) begin : g_msb
`ifdef SIGN_EXT_B_EN
                // Sign of the (A_WIDTH+1)-bit two's complement result.
                assign c_store = op_a[IN_W-1] ^ op_b[IN_W-1] ^ seg_cout;
`else
                assign c_store = seg_cout;
`endif
            end else begin : g_mid
                assign c_store = seg_cout;
            end

            if (REM > 0) begin : g_fwd
                // Upper operand bits ride along until their segment comes up.
                always_ff @(posedge clk) begin
                    if (advance) begin
                        a_r <= op_a[IN_W-1:W];
                        b_r <= op_b[IN_W-1:W];
                    end
                end
            end else begin : g_tail
                assign a_r = '0;
                assign b_r = '0;
            end
        end else begin : g_pass
            // Segment left empty by the rounding: result passes straight on.
            assign s_next  = g_stage[k-1].s_r;
            assign c_store = c_in;
            assign a_r     = '0;
            assign b_r     = '0;
        end

        if (REM == 0) begin : g_sink
            logic unused_ops;
            assign unused_ops = ^{a_r, b_r};
        end

        // Control and result registers: cleared by reset, frozen on stall.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (advance) begin
                v_r <= v_in;
                c_r <= c_store;
                s_r <= s_next;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_r;
    assign Sum       = {g_stage[STAGES-1].c_r, g_stage[STAGES-1].s_r};

endmodule

// File: tb/tb_pipelined_custom_adder.sv
// tb_pipelined_custom_adder: scoreboard bench for the pipelined adder.
// Four instances share operands: the main one (STAGES=4) sees the driven
// out_ready; STAGES=1/3/62 instances see the pairs the main one accepts and
// always drain, so their latency can be checked exactly.
`timescale 1ns/1ps
module tb_pipelined_custom_adder;

    localparam int AW = 62;
    localparam int BW = 17;
    localparam int NI = 4;

    function automatic int stages_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 3;
            default: return 62;
        endcase
    endfunction

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [AW-1:0] a_in;
    logic [BW-1:0] b_in;

    logic          iv        [NI];
    logic          ordy      [NI];
    logic          in_ready  [NI];
    logic          out_valid [NI];
    logic [AW:0]   sum       [NI];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    logic lat_chk;

    logic [AW:0] exp_q [NI][$];
    int          cyc_q [NI][$];

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int S = stages_of(g);

        if (g == 0) begin : g_main
            assign iv[g]   = in_valid;
            assign ordy[g] = out_ready;
        end else begin : g_follow
            assign iv[g]   = in_valid && in_ready[0];
            assign ordy[g] = 1'b1;
        end

        pipelined_custom_adder #(
            .A_WIDTH (AW),
            .B_WIDTH (BW),
            .STAGES  (S)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (in_ready[g]),
            .A         (a_in),
            .B         (b_in),
            .out_valid (out_valid[g]),
            .out_ready (ordy[g]),
            .Sum       (sum[g])
        );

        // monitor: pop and compare on every result transfer
        logic [AW:0] e;
        int          c0;
        logic        lat_en;
        always @(negedge clk) begin
            if (rst_n && out_valid[g] && ordy[g]) begin
                tests++;
                if (exp_q[g].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out[S=%0d] got Sum=%h, expected no output", S, sum[g]);
                end else begin
                    e  = exp_q[g].pop_front();
                    c0 = cyc_q[g].pop_front();
                    if (sum[g] !== e) begin
                        fails++;
                        $display("FAIL sum[S=%0d] got %h, expected %h", S, sum[g], e);
                    end
                    lat_en = (g != 0) || lat_chk;
                    if (lat_en) begin
                        tests++;
                        if (cyc - c0 != S) begin
                            fails++;
                            $display("FAIL latency[S=%0d] got %0d, expected %0d", S, cyc - c0, S);
                        end
                    end
                end
            end
        end
    end

    // scoreboard reference: A + ext(B) at AW+1 bits
    function automatic logic [AW:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b);
`ifdef SIGN_EXT_B_EN
        logic signed [AW:0] sa;
        logic signed [AW:0] sb;
        sa = (AW+1)'($signed(a));
        sb = (AW+1)'($signed(b));
        return sa + sb;
`else
        return {1'b0, a} + (AW+1)'(b);
`endif
    endfunction

    task automatic check(input string name, input logic [AW:0] got, input logic [AW:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got %h, expected %h", name, got, expv);
        end
    endtask

    // driver: present a pair, push expectation on the accepting edge
    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [AW:0] e);
        int   waited;
        logic done;
        waited   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready[0]) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL accept_timeout got no in_ready in %0d cycles, expected acceptance", waited);
                    done = 1'b1;
                end
            end
        end
        if (waited <= 200) begin
            for (int g = 0; g < NI; g++) begin
                exp_q[g].push_back(e);
                cyc_q[g].push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic int pending();
        int n;
        n = 0;
        for (int g = 0; g < NI; g++) n += exp_q[g].size();
        return n;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (pending() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", (AW+1)'(pending()), '0);
    endtask

    // directed vectors
    logic [AW-1:0] va [7];
    logic [BW-1:0] vb [7];
    logic [AW:0]   ve [7];

    initial begin
        logic [63:0]   r64;
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        int            c_start;

        va[0] = 62'h3FFF_FFFF_FFFF_FFFF; vb[0] = 17'h00001;
        va[1] = 62'h0;                   vb[1] = 17'h00000;
        va[2] = 62'h3FFF_FFFF_FFFF_FFFF; vb[2] = 17'h1FFFF;
        va[3] = 62'd5;                   vb[3] = 17'h1FFFF;
        va[4] = 62'h0000_0000_0000_FFFF; vb[4] = 17'h00001;
        va[5] = 62'h0000_FFFF_FFFF_0000; vb[5] = 17'h10000;
        va[6] = 62'h2000_0000_0000_0000; vb[6] = 17'h0FFFF;
`ifdef SIGN_EXT_B_EN
        ve[0] = 63'h0;
        ve[1] = 63'h0;
        ve[2] = 63'h7FFF_FFFF_FFFF_FFFE;
        ve[3] = 63'd4;
        ve[4] = 63'h0000_0000_0001_0000;
        ve[5] = 63'h0000_FFFF_FFFE_0000;
        ve[6] = 63'h6000_0000_0000_FFFF;
`else
        ve[0] = 63'h4000_0000_0000_0000;
        ve[1] = 63'h0;
        ve[2] = 63'h4000_0000_0001_FFFE;
        ve[3] = 63'd131076;
        ve[4] = 63'h0000_0000_0001_0000;
        ve[5] = 63'h0001_0000_0000_0000;
        ve[6] = 63'h2000_0000_0000_FFFF;
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        lat_chk   = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset_out_valid[%0d]", g), (AW+1)'(out_valid[g]), '0);
            check($sformatf("reset_sum[%0d]", g), sum[g], '0);
        end
        check("reset_in_ready", (AW+1)'(in_ready[0]), (AW+1)'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single all-ones carry case on an idle pipe
        send(va[0], vb[0], ve[0]);
        drain();

        // directed vectors back to back
        for (int i = 0; i < 7; i++) send(va[i], vb[i], ve[i]);
        drain();

        // 100-pair stream, one acceptance per cycle
        c_start = cyc;
        for (int i = 0; i < 100; i++) begin
            r64 = {$urandom(), $urandom()};
            ra  = r64[AW-1:0];
            rb  = BW'($urandom_range(131071, 0));
            send(ra, rb, model(ra, rb));
        end
        check("stream_cycles", (AW+1)'(cyc - c_start), (AW+1)'(100));
        drain();

        // output stall with a full pipe
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        for (int i = 2; i < 6; i++) send(va[i], vb[i], ve[i]);
        fork
            send(va[6], vb[6], ve[6]);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", (AW+1)'(in_ready[0]), '0);
                    check("stall_out_valid", (AW+1)'(out_valid[0]), (AW+1)'(1));
                    check("stall_sum_hold", sum[0], ve[2]);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset in the middle of a burst discards everything in flight
        send(va[2], vb[2], ve[2]);
        send(va[3], vb[3], ve[3]);
        send(va[0], vb[0], ve[0]);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a_in     = va[5];
        b_in     = vb[5];
        for (int g = 0; g < NI; g++) begin
            exp_q[g].delete();
            cyc_q[g].delete();
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("post_reset_out_valid[%0d]", g), (AW+1)'(out_valid[g]), '0);
            check($sformatf("post_reset_sum[%0d]", g), sum[g], '0);
        end
        check("post_reset_in_ready", (AW+1)'(in_ready[0]), (AW+1)'(1));
        repeat (70) @(posedge clk);
        #1;
        lat_chk = 1'b1;

        // recovery after reset
        send(va[2], vb[2], ve[2]);
        send(va[6], vb[6], ve[6]);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_custom_adder.md
PIPELINED_CUSTOM_ADDER -- requirements
Module: pipelined_custom_adder

Interface
REQ-001 Parameter A_WIDTH, default 62: width of operand A; SHALL be >= 2.
REQ-002 Parameter B_WIDTH, default 17: width of operand B; SHALL satisfy 1 <= B_WIDTH <= A_WIDTH.
REQ-003 Parameter STAGES, default 4: number of carry segments and pipeline stages; SHALL satisfy 1 <= STAGES <= A_WIDTH.
REQ-004 Port clk, input, 1: the single clock; every flop SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1: the operand pair is presented.
REQ-007 Port in_ready, output, 1: the block accepts an operand pair this cycle.
REQ-008 Port A, input, A_WIDTH: operand A.
REQ-009 Port B, input, B_WIDTH: operand B, extended to A_WIDTH before the add.
REQ-010 Port out_valid, output, 1: Sum holds a completed result.
REQ-011 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-012 Port Sum, output, A_WIDTH+1: the result, including the carry-out or sign bit in the MSB.

Function
REQ-013 The operand SHALL transfer on a cycle with in_valid && in_ready; the result SHALL transfer on a cycle with out_valid && out_ready.
REQ-014 The extension of B SHALL be {(A_WIDTH-B_WIDTH)'b0, B}, except as changed by REQ-026.
REQ-015 The adder SHALL be split LSB-first into STAGES segments of SEG = ceil(A_WIDTH/STAGES) bits; the last segment takes the remainder.
REQ-016 Stage k SHALL ripple-add segment k, using the carry registered from stage k-1; the carry-in of stage 0 SHALL be 0.
REQ-017 Operand bits of segments above k SHALL travel with the data through delay registers; completed sum segments SHALL travel forward with it.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when the block is not stalled; throughput SHALL be 1 result per cycle.
REQ-019 The pipeline advance SHALL be advance = !out_valid || out_ready, and in_ready SHALL equal advance.
REQ-020 While stalled, all stage registers and Sum SHALL hold their values and no operand SHALL be accepted, even if in_valid=1.
REQ-021 Bubbles SHALL propagate as valid=0 slots; bubbles are not collapsed.
REQ-022 Sum SHALL be bit-exact with A + ext(B) at A_WIDTH+1 bits for every input, including all-ones operands where the full carry chain propagates.
REQ-023 When STAGES=1, the block SHALL be a single registered adder with latency 1.

Reset
REQ-024 While rst_n=0 at a clock edge, the following SHALL clear to 0: out_valid, every stage valid bit, every carry register, and Sum. in_ready SHALL read 1 on the cycle after reset.
REQ-025 A reset asserted mid-operation SHALL discard all in-flight operands; no out_valid SHALL be produced for them after rst_n returns to 1.

Configuration
REQ-026 Macro SIGN_EXT_B_EN:
  - Defined: A and B are two's complement; B SHALL be sign-extended; Sum SHALL equal the signed A_WIDTH+1-bit result, with Sum[A_WIDTH] as the sign.
  - Undefined: B SHALL be zero-extended as in REQ-014, and the arithmetic is unsigned.

Structure
REQ-027 Package adder_pkg SHALL hold the parameter defaults (62/17/4) and a ceil-divide function used to compute SEG.
REQ-028 Sub-module adder_segment SHALL implement one parametrised ripple segment (width, cin, cout); pipelined_custom_adder SHALL instantiate STAGES copies of it with generate.

Verification
REQ-029 Defaults; A=62'h3FFF_FFFF_FFFF_FFFF, B=17'h1 -> after 4 cycles Sum=63'h4000_0000_0000_0000 and out_valid=1.
REQ-030 Defaults; back-to-back stream of 100 random pairs with out_ready=1 -> one result per cycle, in order, each matching the model.
REQ-031 Defaults; out_ready=0 for 5 cycles while the pipeline is full -> in_ready=0, Sum is held, and there is no loss or duplication after release.
REQ-032 rst_n=0 for one cycle at cycle 2 of a 4-pair burst -> none of the 4 results ever appear; out_valid=0 and in_ready=1 after reset.
REQ-033 SIGN_EXT_B_EN defined; A=62'd5, B=17'h1FFFF (-1) -> Sum=63'd4. With the macro undefined, the same inputs -> Sum=63'd131076.
REQ-034 Sweep STAGES in {1, 3, 62} with A_WIDTH=62 and B_WIDTH=17 -> latency equals STAGES and results are bit-exact.
